// File: rtl/llc_mem_ctrl_if.sv
// Request/response and local-memory port bundle for llc_mem_ctrl.
// master: requester/datapath side; slave: the controller.
interface llc_mem_ctrl_if #(
  parameter int unsigned SET_BITS = 10,
  parameter int unsigned WAY_BITS = 4
);
  logic                         flush_req;
  logic                         rd_req_valid;
  logic [SET_BITS-1:0]          rd_req_set;
  logic                         rd_req_ready;
  logic                         rd_rsp_valid;
  logic                         wr_req_valid;
  logic [SET_BITS-1:0]          wr_req_set;
  logic [WAY_BITS-1:0]          wr_req_way;
  logic                         wr_req_ready;
  logic                         mem_rd_en;
  logic [SET_BITS-1:0]          mem_rd_set;
  logic                         mem_wr_en;
  logic [SET_BITS+WAY_BITS-1:0] mem_wr_addr;
  logic                         mem_wr_clear;
  logic                         init_done;

  modport master (
    output flush_req, rd_req_valid, rd_req_set, wr_req_valid, wr_req_set, wr_req_way,
    input  rd_req_ready, rd_rsp_valid, wr_req_ready, mem_rd_en, mem_rd_set, mem_wr_en,
    input  mem_wr_addr, mem_wr_clear, init_done
  );

  modport slave (
    input  flush_req, rd_req_valid, rd_req_set, wr_req_valid, wr_req_set, wr_req_way,
    output rd_req_ready, rd_rsp_valid, wr_req_ready, mem_rd_en, mem_rd_set, mem_wr_en,
    output mem_wr_addr, mem_wr_clear, init_done
  );
endinterface

// File: rtl/llc_mem_ctrl.sv
// LLC local-memory sequencer: clearing sweep after reset/flush, then read/write arbitration.
// Define LLC_MEM_CTRL_STATS_EN to add saturating accepted-read/write counters.
module llc_mem_ctrl #(
  parameter int unsigned SET_BITS   = 10,
  parameter int unsigned WAY_BITS   = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  llc_mem_ctrl_if.slave bus
`ifdef LLC_MEM_CTRL_STATS_EN
  ,
  output logic [31:0]   stat_rd_cnt,
  output logic [31:0]   stat_wr_cnt
`endif
);

  localparam int unsigned AddrW   = SET_BITS + WAY_BITS;
  localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  typedef enum logic [1:0] {
    StPre,
    StInit,
    StRun
  } state_e;

  state_e              state_q, state_d;
  logic [AddrW-1:0]    cnt_q, cnt_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                init_done_q, init_done_d;
  logic                rd_rsp_q;

  logic                rd_prio;
  logic                same_set;
  logic                rd_grant;
  logic                wr_grant;
  logic                wr_en;
  logic                wr_clear;
  logic [AddrW-1:0]    wr_addr;
  logic [SET_BITS-1:0] rd_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPre;
      cnt_q       <= '0;
      starve_q    <= '0;
      init_done_q <= 1'b0;
      rd_rsp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      init_done_q <= init_done_d;
      rd_rsp_q    <= rd_grant;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    init_done_d = init_done_q;
    rd_grant    = 1'b0;
    wr_grant    = 1'b0;
    wr_en       = 1'b0;
    wr_clear    = 1'b0;
    wr_addr     = '0;
    rd_set      = '0;
    rd_prio     = (starve_q >= StarveMax);
    same_set    = (bus.rd_req_set == bus.wr_req_set);

    unique case (state_q)
      StPre: begin
        state_d = StInit;
        cnt_d   = '0;
      end

      StInit: begin
        wr_en    = 1'b1;
        wr_clear = 1'b1;
        wr_addr  = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end

      StRun: begin
        // Write wins a same-set conflict unless the read has been starved long enough.
        wr_grant = bus.wr_req_valid & ~(rd_prio & bus.rd_req_valid & same_set);
        rd_grant = bus.rd_req_valid & ~(wr_grant & same_set);
        wr_en    = wr_grant;
        wr_addr  = {bus.wr_req_set, bus.wr_req_way};
        rd_set   = bus.rd_req_set;

        if (rd_grant) begin
          starve_d = '0;
        end else if (bus.rd_req_valid && !rd_prio) begin
          starve_d = starve_q + 1'b1;
        end

        // Requests seen alongside the flush are still granted this cycle.
        if (bus.flush_req) begin
          state_d     = StInit;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end
      end

      default: begin
        state_d = StPre;
      end
    endcase
  end

  assign bus.rd_req_ready = rd_grant;
  assign bus.wr_req_ready = wr_grant;
  assign bus.mem_rd_en    = rd_grant;
  assign bus.mem_rd_set   = rd_set;
  assign bus.mem_wr_en    = wr_en;
  assign bus.mem_wr_addr  = wr_addr;
  assign bus.mem_wr_clear = wr_clear;
  assign bus.rd_rsp_valid = rd_rsp_q;
  assign bus.init_done    = init_done_q;

`ifdef LLC_MEM_CTRL_STATS_EN
  logic        enter_init;
  logic [31:0] stat_rd_q;
  logic [31:0] stat_wr_q;

  assign enter_init = (state_d == StInit) && (state_q != StInit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else if (enter_init) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      if (rd_grant && (stat_rd_q != '1)) begin
        stat_rd_q <= stat_rd_q + 32'd1;
      end
      if (wr_grant && (stat_wr_q != '1)) begin
        stat_wr_q <= stat_wr_q + 32'd1;
      end
    end
  end

  assign stat_rd_cnt = stat_rd_q;
  assign stat_wr_cnt = stat_wr_q;
`endif

endmodule

// File: tb/tb_llc_mem_ctrl.sv
// Scoreboard bench for llc_mem_ctrl (SET_BITS=4, WAY_BITS=2, STARVE_MAX=4).
// Build with LLC_MEM_CTRL_STATS_EN defined to also exercise the stat counters.
module tb_llc_mem_ctrl;
  localparam int unsigned SB = 4;
  localparam int unsigned WB = 2;

  typedef struct {
    int         cyc;
    logic [5:0] addr;
    logic       clr;
    logic       rdy;
  } wr_exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] set;
  } rd_exp_t;

  typedef struct {
    int   cyc;
    logic val;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  wr_exp_t   wq[$];
  rd_exp_t   rq[$];
  int        sq[$];
  done_exp_t dq[$];

  llc_mem_ctrl_if #(.SET_BITS(SB), .WAY_BITS(WB)) bus ();

`ifdef LLC_MEM_CTRL_STATS_EN
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_wr_cnt;
`endif

  llc_mem_ctrl #(
    .SET_BITS  (SB),
    .WAY_BITS  (WB),
    .STARVE_MAX(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef LLC_MEM_CTRL_STATS_EN
    ,
    .stat_rd_cnt(stat_rd_cnt),
    .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input string act, input string req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int c, input int a, input bit clr, input bit rdy);
    wr_exp_t e;
    e.cyc = c; e.addr = 6'(a); e.clr = clr; e.rdy = rdy;
    wq.push_back(e);
  endtask

  task automatic push_rd(input int c, input int s);
    rd_exp_t e;
    e.cyc = c; e.set = 4'(s);
    rq.push_back(e);
    sq.push_back(c + 1);
  endtask

  task automatic push_done(input int c, input bit v);
    done_exp_t e;
    e.cyc = c; e.val = v;
    dq.push_back(e);
  endtask

  task automatic push_sweep(input int first);
    for (int i = 0; i < 64; i++) push_wr(first + i, i, 1'b1, 1'b0);
  endtask

  task automatic drive(input bit rv, input int rs, input bit wv, input int ws, input int ww);
    bus.rd_req_valid = rv;
    bus.rd_req_set   = 4'(rs);
    bus.wr_req_valid = wv;
    bus.wr_req_set   = 4'(ws);
    bus.wr_req_way   = 2'(ww);
  endtask

  // Monitor: every observed DUT event must match the head of its expectation queue.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_wr_en || bus.wr_req_ready) begin
      wr_exp_t e;
      e = '{cyc: -1, addr: 6'h0, clr: 1'b0, rdy: 1'b0};
      if (wq.size() != 0) e = wq.pop_front();
      check(cyc == e.cyc && bus.mem_wr_en && bus.mem_wr_addr == e.addr &&
            bus.mem_wr_clear == e.clr && bus.wr_req_ready == e.rdy, "mem_write",
            $sformatf("cyc=%0d en=%0b addr=%0h clr=%0b rdy=%0b", cyc, bus.mem_wr_en,
                      bus.mem_wr_addr, bus.mem_wr_clear, bus.wr_req_ready),
            $sformatf("cyc=%0d en=1 addr=%0h clr=%0b rdy=%0b", e.cyc, e.addr, e.clr, e.rdy));
    end
    if (bus.mem_rd_en || bus.rd_req_ready) begin
      rd_exp_t e;
      e = '{cyc: -1, set: 4'h0};
      if (rq.size() != 0) e = rq.pop_front();
      check(cyc == e.cyc && bus.mem_rd_en && bus.rd_req_ready && bus.mem_rd_set == e.set,
            "mem_read",
            $sformatf("cyc=%0d en=%0b rdy=%0b set=%0h", cyc, bus.mem_rd_en, bus.rd_req_ready,
                      bus.mem_rd_set),
            $sformatf("cyc=%0d en=1 rdy=1 set=%0h", e.cyc, e.set));
    end
    if (bus.rd_rsp_valid) begin
      int c;
      c = -1;
      if (sq.size() != 0) c = sq.pop_front();
      check(cyc == c, "rd_rsp_valid", $sformatf("cyc=%0d", cyc), $sformatf("cyc=%0d", c));
    end
    if (bus.init_done !== done_prev) begin
      done_exp_t e;
      e = '{cyc: -1, val: 1'b0};
      if (dq.size() != 0) e = dq.pop_front();
      check(cyc == e.cyc && bus.init_done === e.val, "init_done",
            $sformatf("cyc=%0d val=%0b", cyc, bus.init_done),
            $sformatf("cyc=%0d val=%0b", e.cyc, e.val));
      done_prev = bus.init_done;
    end
  end

  initial begin
    int c;
    rst = 1'b1;
    bus.flush_req = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) tick();

    // Power-up: one idle cycle, then the 64-entry clearing sweep.
    rst = 1'b0;
    c = cyc;
    push_sweep(c + 1);
    push_done(c + 65, 1'b1);
    repeat (65) tick();
    tick();

    // Different sets: both granted in one cycle.
    c = cyc;
    drive(1, 3, 1, 5, 2);
    push_rd(c, 3);
    push_wr(c, 6'h16, 1'b0, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();

    // Same set held six cycles: four writes, then starved read, then write.
    c = cyc;
    drive(1, 7, 1, 7, 1);
    for (int i = 0; i < 4; i++) push_wr(c + i, 6'h1D, 1'b0, 1'b1);
    push_rd(c + 4, 7);
    push_wr(c + 5, 6'h1D, 1'b0, 1'b1);
    repeat (6) tick();
    drive(0, 0, 0, 0, 0);
    tick();

    // Flush with requests in the same cycle; requests and flush stay high during the sweep.
    c = cyc;
    bus.flush_req = 1'b1;
    drive(1, 9, 1, 2, 3);
    push_rd(c, 9);
    push_wr(c, 6'h0B, 1'b0, 1'b1);
    push_done(c + 1, 1'b0);
    push_sweep(c + 1);
    push_done(c + 65, 1'b1);
    repeat (64) tick();
    bus.flush_req = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();

    // Traffic for the stat counters: 3 reads, 2 writes.
    c = cyc;
    drive(1, 1, 1, 2, 0);
    push_rd(c, 1);
    push_wr(c, 6'h08, 1'b0, 1'b1);
    tick();
    drive(1, 4, 1, 6, 3);
    push_rd(c + 1, 4);
    push_wr(c + 1, 6'h1B, 1'b0, 1'b1);
    tick();
    drive(1, 8, 0, 0, 0);
    push_rd(c + 2, 8);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
`ifdef LLC_MEM_CTRL_STATS_EN
    check(stat_rd_cnt == 32'd3, "stat_rd_cnt", $sformatf("%0d", stat_rd_cnt), "3");
    check(stat_wr_cnt == 32'd2, "stat_wr_cnt", $sformatf("%0d", stat_wr_cnt), "2");
`endif
    c = cyc;
    bus.flush_req = 1'b1;
    push_done(c + 1, 1'b0);
    push_sweep(c + 1);
    push_done(c + 65, 1'b1);
    tick();
    bus.flush_req = 1'b0;
`ifdef LLC_MEM_CTRL_STATS_EN
    check(stat_rd_cnt == 32'd0, "stat_rd_flush", $sformatf("%0d", stat_rd_cnt), "0");
    check(stat_wr_cnt == 32'd0, "stat_wr_flush", $sformatf("%0d", stat_wr_cnt), "0");
`endif
    repeat (64) tick();
    tick();

    // Reset while the sweep presents entry 20: outputs drop at once, sweep restarts at 0.
    c = cyc;
    bus.flush_req = 1'b1;
    push_done(c + 1, 1'b0);
    for (int i = 0; i < 20; i++) push_wr(c + 1 + i, i, 1'b1, 1'b0);
    tick();
    bus.flush_req = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    c = cyc;
    push_sweep(c + 1);
    push_done(c + 65, 1'b1);
    repeat (65) tick();
    repeat (3) tick();

    check(wq.size() == 0, "wr_queue_drained", $sformatf("%0d left", wq.size()), "0 left");
    check(rq.size() == 0, "rd_queue_drained", $sformatf("%0d left", rq.size()), "0 left");
    check(sq.size() == 0, "rsp_queue_drained", $sformatf("%0d left", sq.size()), "0 left");
    check(dq.size() == 0, "done_queue_drained", $sformatf("%0d left", dq.size()), "0 left");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
